// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl shared types: sequencer states and depth limit.
// Imported by pipe_ctrl and pipe_ctrl_occ.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pipe_state_t;

  localparam int PIPE_MAX_DEP = 32;

endpackage

// File: rtl/pipe_ctrl_occ.sv
// Up/down occupancy counter with synchronous clear.
// Exposes next value so the sequencer can see the count it is moving to.
module pipe_ctrl_occ
  import pipe_ctrl_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_nxt
);

  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (inc & ~dec)
      cnt_nxt = cnt + CW'(1);
    else if (dec & ~inc)
      cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Valid-tracking sequencer for a DEP-stage clock-enabled pipeline.
// PIPE_CTRL_COLLAPSE_EN: per-stage enables that squeeze out bubbles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DEP = 4,
  parameter int CW  = $clog2(DEP+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  input  logic           flush,
  input  logic           drain_req,
  output logic           drained,
  output logic [DEP-1:0] stage_ce,
  output logic [DEP-1:0] stage_valid,
  output logic [CW-1:0]  occ
);

  pipe_state_t    state;
  pipe_state_t    state_n;
  logic           drained_n;
  logic           acc;
  logic           emt;
  logic [DEP-1:0] sv_n;
  logic [CW-1:0]  occ_nxt;

  assign out_valid = stage_valid[DEP-1];
  assign acc       = in_valid & in_ready;
  assign emt       = out_valid & out_ready;
  assign in_ready  = stage_ce[0] & ~flush & (state != DRAIN);

`ifdef PIPE_CTRL_COLLAPSE_EN
  // Stage k may load unless it and every stage after it is full.
  always_comb begin
    logic full;
    full     = out_ready ? 1'b0 : 1'b1;
    stage_ce = '0;
    for (int k = DEP-1; k >= 0; k--) begin
      full        = full & stage_valid[k];
      stage_ce[k] = ~full;
    end
  end
`else
  always_comb begin
    stage_ce = {DEP{~stage_valid[DEP-1] | out_ready}};
  end
`endif

  always_comb begin
    sv_n = stage_valid;
    if (stage_ce[0])
      sv_n[0] = acc;
    for (int k = 1; k < DEP; k++)
      if (stage_ce[k])
        sv_n[k] = stage_valid[k-1];
    if (flush)
      sv_n = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stage_valid <= '0;
    else
      stage_valid <= sv_n;
  end

  pipe_ctrl_occ #(
    .CW(CW)
  ) u_occ (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .inc    (acc),
    .dec    (emt),
    .cnt    (occ),
    .cnt_nxt(occ_nxt)
  );

  always_comb begin
    state_n   = state;
    drained_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (drain_req & ~acc)
          drained_n = 1'b1;
        else if (acc)
          state_n = drain_req ? DRAIN : RUN;
      end
      RUN: begin
        if (occ_nxt == '0 && !acc) begin
          state_n   = IDLE;
          drained_n = drain_req;
        end else if (drain_req) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (occ_nxt == '0) begin
          state_n   = IDLE;
          drained_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (flush) begin
      state_n   = IDLE;
      drained_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      drained <= 1'b0;
    end else begin
      state   <= state_n;
      drained <= drained_n;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl, DEP=4.
// Expectations follow PIPE_CTRL_COLLAPSE_EN when it is defined.
module tb_pipe_ctrl;

  localparam int DEP = 4;
  localparam int CW  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready;
  logic           flush;
  logic           drain_req;
  logic           drained;
  logic [DEP-1:0] stage_ce;
  logic [DEP-1:0] stage_valid;
  logic [CW-1:0]  occ;

  int tests = 0;
  int fails = 0;

  pipe_ctrl #(
    .DEP(DEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush      (flush),
    .drain_req  (drain_req),
    .drained    (drained),
    .stage_ce   (stage_ce),
    .stage_valid(stage_valid),
    .occ        (occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first;
    int last;
    int emits;
    int peak;
    int zc;
    int dc;
    int dn;
    int good;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    drain_req = 1'b0;
    #12;
    rst = 1'b0;
    #1;
    chk("rst_sv", stage_valid, 4'b0000);
    chk("rst_occ", occ, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_drained", drained, 0);
    chk("rst_ce", stage_ce, 4'b1111);
    chk("rst_ir", in_ready, 1);
    tick();

    // streaming: 6 items, out_ready high
    out_ready = 1'b1;
    first = -1; last = -1; emits = 0; peak = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 6);
      #1;
      if (out_valid && out_ready) begin
        if (first < 0) first = c;
        last = c;
        emits++;
      end
      if (int'(occ) > peak) peak = int'(occ);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("stream_first_out", first, 4);
    chk("stream_last_out", last, 9);
    chk("stream_emits", emits, 6);
    chk("stream_peak", peak, 4);
    chk("stream_end_occ", occ, 0);

    // stall: accept, idle, accept, idle, accept, idle x3
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c == 0 || c == 2 || c == 4);
      tick();
    end
    in_valid = 1'b0;
    #1;
`ifdef PIPE_CTRL_COLLAPSE_EN
    chk("stall_sv", stage_valid, 4'b1110);
    chk("stall_occ", occ, 3);
    chk("stall_ir", in_ready, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("stall_full_sv", stage_valid, 4'b1111);
    chk("stall_full_occ", occ, 4);
    chk("stall_full_ir", in_ready, 0);
`else
    chk("stall_sv", stage_valid, 4'b1010);
    chk("stall_occ", occ, 2);
    chk("stall_ir", in_ready, 0);
    chk("stall_ce", stage_ce, 4'b0000);
`endif

    // flush with in_valid high
    flush    = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("flush_ir", in_ready, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_occ", occ, 0);
    chk("flush_sv", stage_valid, 4'b0000);
    chk("flush_drained", drained, 0);
    chk("flush_idle_ir", in_ready, 1);

    // drain from occ=3
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    #1;
    chk("drain_occ3", occ, 3);
    out_ready = 1'b1;
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    zc = -1; dc = -1; dn = 0;
    for (int c = 1; c < 7; c++) begin
      in_valid = (c == 1);
      #1;
      if (c == 1) chk("drain_ir", in_ready, 0);
      if (occ == 0 && zc < 0) zc = c;
      if (drained) begin
        dn++;
        if (dc < 0) dc = c;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("drain_zero_cyc", zc, 4);
    chk("drain_pulse_cyc", dc, 4);
    chk("drain_pulses", dn, 1);
    #1;
    chk("drain_idle_ir", in_ready, 1);

    // fill to 4, then full-rate accept+emit
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (4) tick();
    #1;
    chk("full_occ", occ, 4);
    chk("full_sv", stage_valid, 4'b1111);
    out_ready = 1'b1;
    good = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (in_ready && out_valid && occ == 4) good++;
      tick();
    end
    chk("rate_cycles", good, 10);
    chk("rate_occ", occ, 4);
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;

    // drain request while idle
    drain_req = 1'b1;
    #1;
    chk("idle_drain_pre", drained, 0);
    tick();
    drain_req = 1'b0;
    #1;
    chk("idle_drain_pulse", drained, 1);
    chk("idle_drain_ir", in_ready, 1);
    tick();
    #1;
    chk("idle_drain_end", drained, 0);

    // async reset with two items in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    repeat (2) tick();
    chk("prerst_sv", stage_valid, 4'b1100);
    chk("prerst_occ", occ, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ov", out_valid, 0);
    chk("arst_occ", occ, 0);
    chk("arst_sv", stage_valid, 4'b0000);
    chk("arst_drained", drained, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
